// File: rtl/irrigation_pkg.sv
// Shared types and 7-segment status codes for the two-zone irrigation controller.
package irrigation_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      WATER    = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_ZONE0 = 8'h3F;
   localparam logic [7:0] SEG_ZONE1 = 8'h06;
   localparam logic [7:0] SEG_COOL  = 8'h40;

   // Digit shown while a zone is being served.
   function automatic logic [7:0] zone_seg(input logic zone);
      return zone ? SEG_ZONE1 : SEG_ZONE0;
   endfunction

endpackage

// File: rtl/irrigation_controller_rr_arbiter2.sv
// Two-requester round-robin arbiter: a tie goes to the zone not served last.
module rr_arbiter2 (
   input  logic [1:0] dry,
   input  logic       last_served,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |dry;
      grant = 1'b0;
      case (dry)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_served;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/irrigation_controller.sv
// Shares one pump between two zones: grant, valve settle, watering, cooldown.
module irrigation_controller
   import irrigation_pkg::*;
#(
   parameter int unsigned WATER_TICKS    = 5,
   parameter int unsigned COOLDOWN_TICKS = 2,
   parameter int unsigned NBITS_CNT      = 8
) (
   input  logic                 clk_2,
   input  logic                 reset_n,
   input  logic [1:0]           dry,
   input  logic                 enable,
   output logic [1:0]           valve,
   output logic                 pump,
   output logic                 busy,
   output logic [7:0]           seg,
   output logic [NBITS_CNT-1:0] served
);

   localparam int unsigned CNT_MAX = (WATER_TICKS > COOLDOWN_TICKS) ? WATER_TICKS : COOLDOWN_TICKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 zone, zone_nxt;
   logic                 last_served, last_nxt;
   logic [NBITS_CNT-1:0] served_nxt;
   logic [1:0]           valve_nxt;
   logic                 pump_nxt, busy_nxt;
   logic [7:0]           seg_nxt;
   logic                 arb_grant, arb_valid;

   rr_arbiter2 u_arb (
      .dry         (dry),
      .last_served (last_served),
      .grant       (arb_grant),
      .valid       (arb_valid)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         zone        <= 1'b0;
         last_served <= 1'b1;
         served      <= '0;
         valve       <= '0;
         pump        <= 1'b0;
         busy        <= 1'b0;
         seg         <= SEG_BLANK;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         zone        <= zone_nxt;
         last_served <= last_nxt;
         served      <= served_nxt;
         valve       <= valve_nxt;
         pump        <= pump_nxt;
         busy        <= busy_nxt;
         seg         <= seg_nxt;
      end
   end

   // Next state, bookkeeping, and outputs decoded from the state being entered.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt + CNT_W'(1);
      zone_nxt   = zone;
      last_nxt   = last_served;
      served_nxt = served;
      valve_nxt  = '0;
      pump_nxt   = 1'b0;
      busy_nxt   = 1'b0;
      seg_nxt    = SEG_BLANK;

      case (state)
         IDLE: begin
            if (enable && arb_valid) begin
               state_nxt = SETTLE;
               zone_nxt  = arb_grant;
            end
         end
         SETTLE: begin
            state_nxt = enable ? WATER : COOLDOWN;
         end
         WATER: begin
            // An abort wins even on the final tick: no credit for a cut-short service.
            if (!enable) begin
               state_nxt = COOLDOWN;
            end else if (cnt == CNT_W'(WATER_TICKS - 1)) begin
               state_nxt = COOLDOWN;
               last_nxt  = zone;
               if (served != '1) served_nxt = served + NBITS_CNT'(1);
            end
         end
         COOLDOWN: begin
            if (cnt == CNT_W'(COOLDOWN_TICKS - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt != state || state == IDLE) cnt_nxt = '0;

      busy_nxt = (state_nxt != IDLE);
      case (state_nxt)
         SETTLE: begin
            valve_nxt = zone_nxt ? 2'b10 : 2'b01;
            seg_nxt   = zone_seg(zone_nxt);
         end
         WATER: begin
            valve_nxt = zone_nxt ? 2'b10 : 2'b01;
            pump_nxt  = 1'b1;
            seg_nxt   = zone_seg(zone_nxt);
         end
         COOLDOWN: seg_nxt = SEG_COOL;
         default:  seg_nxt = SEG_BLANK;
      endcase
   end

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed bench for irrigation_controller: vector table plus multi-cycle sequences.
module tb_irrigation_controller;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic [1:0] dry;
   logic       enable;
   logic [1:0] valve;
   logic       pump, busy;
   logic [7:0] seg;
   logic [7:0] served;
   logic [1:0] valve_s;
   logic       pump_s, busy_s;
   logic [7:0] seg_s;
   logic [1:0] served_s;

   int total = 0;
   int bad   = 0;

   always #5 clk_2 = ~clk_2;

   irrigation_controller dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .dry     (dry),
      .enable  (enable),
      .valve   (valve),
      .pump    (pump),
      .busy    (busy),
      .seg     (seg),
      .served  (served)
   );

   irrigation_controller #(.NBITS_CNT(2)) dut_sat (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .dry     (dry),
      .enable  (enable),
      .valve   (valve_s),
      .pump    (pump_s),
      .busy    (busy_s),
      .seg     (seg_s),
      .served  (served_s)
   );

   typedef struct {
      logic       en;
      logic [1:0] dry;
      logic [1:0] valve;
      logic       pump;
      logic       busy;
      logic [7:0] seg;
      logic [7:0] served;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_2);
      #1;
   endtask

   // One complete service from IDLE: settle, watering, cooldown, one idle cycle.
   task automatic service(input logic zone, input int exp_served, input bit drop_dry);
      logic [1:0] exp_valve;
      logic [7:0] exp_seg;
      exp_valve = zone ? 2'b10 : 2'b01;
      exp_seg   = zone ? 8'h06 : 8'h3F;
      step();
      chk("settle_valve", 32'(valve), 32'(exp_valve));
      chk("settle_pump", 32'(pump), 32'd0);
      chk("settle_seg", 32'(seg), 32'(exp_seg));
      if (drop_dry) dry = 2'b00;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("water_pump", 32'(pump), 32'd1);
         chk("water_valve", 32'(valve), 32'(exp_valve));
      end
      step();
      chk("cool_seg", 32'(seg), 32'h40);
      chk("cool_valve", 32'(valve), 32'd0);
      chk("cool_served", 32'(served), 32'(exp_served));
      step();
      chk("cool2_pump", 32'(pump), 32'd0);
      chk("cool2_busy", 32'(busy), 32'd1);
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_seg", 32'(seg), 32'h00);
   endtask

   initial begin
      tbl[0] = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 8'h3F, 8'd0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 8'h3F, 8'd0};
      tbl[6] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 8'h40, 8'd1};
      tbl[7] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 8'h40, 8'd1};
      tbl[8] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'd1};
      tbl[9] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'd1};

      reset_n = 1'b0;
      enable  = 1'b1;
      dry     = 2'b00;
      repeat (2) @(posedge clk_2);
      #1;
      chk("rst_valve", 32'(valve), 32'd0);
      chk("rst_pump", 32'(pump), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_served", 32'(served), 32'd0);
      @(negedge clk_2);
      reset_n = 1'b1;

      // Single zone-0 request with default timing.
      for (int i = 0; i < 10; i++) begin
         enable = tbl[i].en;
         dry    = tbl[i].dry;
         step();
         chk($sformatf("vec%0d_valve", i), 32'(valve), 32'(tbl[i].valve));
         chk($sformatf("vec%0d_pump", i), 32'(pump), 32'(tbl[i].pump));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(tbl[i].seg));
         chk($sformatf("vec%0d_served", i), 32'(served), 32'(tbl[i].served));
      end

      // Held tie alternates 0,1,0,1 from reset with a single idle cycle between.
      #2;
      reset_n = 1'b0;
      dry     = 2'b11;
      @(negedge clk_2);
      reset_n = 1'b1;
      service(1'b0, 1, 1'b0);
      service(1'b1, 2, 1'b0);
      service(1'b0, 3, 1'b0);
      service(1'b1, 4, 1'b0);

      // Abort in the third watering cycle.
      step();
      chk("abort_settle_valve", 32'(valve), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("abort_water_pump", 32'(pump), 32'd1);
      end
      enable = 1'b0;
      step();
      chk("abort_pump", 32'(pump), 32'd0);
      chk("abort_valve", 32'(valve), 32'd0);
      chk("abort_seg", 32'(seg), 32'h40);
      chk("abort_served", 32'(served), 32'd4);
      enable = 1'b1;
      step();
      chk("abort_cool2", 32'(seg), 32'h40);
      step();
      chk("abort_idle", 32'(busy), 32'd0);
      service(1'b0, 5, 1'b0);

      // dry released during settle: service still completes.
      dry = 2'b10;
      service(1'b1, 6, 1'b1);
      step();
      chk("dry0_stay_idle", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of watering.
      dry = 2'b01;
      step();
      step();
      step();
      chk("pre_rst_pump", 32'(pump), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_pump", 32'(pump), 32'd0);
      chk("arst_valve", 32'(valve), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_served", 32'(served), 32'd0);
      chk("arst_served_sat", 32'(served_s), 32'd0);
      dry = 2'b11;
      @(negedge clk_2);
      reset_n = 1'b1;
      service(1'b0, 1, 1'b0);
      chk("sat_served_1", 32'(served_s), 32'd1);

      // Narrow counter saturates at all-ones.
      dry = 2'b01;
      for (int n = 2; n <= 5; n++) begin
         service(1'b0, n, 1'b0);
         chk($sformatf("sat_served_%0d", n), 32'(served_s), (n > 3) ? 32'd3 : 32'(n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/irrigation_controller.md
# irrigation_controller

Sequences a single shared water pump between two irrigation zones, using the per-zone low-humidity flags that the board already decodes from `SWI[1:0]`. A round-robin arbiter picks the zone to serve. An FSM then runs a fixed valve-settle, watering and cooldown cycle, and drives the valve, pump and status outputs. It sits in `top` between the switch inputs and the `LED`/`SEG` outputs.

## Interface
Parameters:
- `WATER_TICKS`, default 5: clock cycles the pump runs per service. Must be ≥1.
- `COOLDOWN_TICKS`, default 2: idle cycles after each service before the next grant. Must be ≥1.
- `NBITS_CNT`, default 8: width of the completed-service counter.

Ports:
- `clk_2`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `dry`, in, 2: `dry[i]`=1 means zone i has low humidity. Level-sensitive and treated as synchronous.
- `enable`, in, 1: master enable. 0 blocks new grants and aborts watering.
- `valve`, out, 2: one-hot open valve. 0 when no zone is served.
- `pump`, out, 1: pump on.
- `busy`, out, 1: 1 in any state other than IDLE.
- `seg`, out, 8: 7-segment status code.
- `served`, out, `NBITS_CNT`: saturating count of completed (non-aborted) waterings.

## Operation
- FSM states are IDLE, SETTLE, WATER and COOLDOWN.
- In IDLE with `enable`=1 and `dry`≠0, the block grants a zone:
  - Only one bit set: grant that zone.
  - Both bits set: grant the zone ≠ `last_served`.
  - Then go to SETTLE.
- IDLE with `enable`=0 or `dry`=0: stay in IDLE.
- SETTLE: `valve`=onehot(grant) and `pump`=0 for exactly 1 cycle, then go to WATER with the tick counter loaded to 0.
- WATER:
  - `pump`=1 and `valve` is held.
  - The counter increments each cycle. When it reaches `WATER_TICKS`-1, go to COOLDOWN and `served` increments (saturates at all-ones).
  - `last_served` is updated to the grant on that same edge.
- `enable` falling during SETTLE or WATER aborts the service:
  - The next state is COOLDOWN.
  - `served` is not incremented and `last_served` is not updated.
- `dry` changing during SETTLE or WATER has no effect; the service runs to completion.
- COOLDOWN: `valve`=0 and `pump`=0 for `COOLDOWN_TICKS` cycles, then go to IDLE. `enable` is ignored.
- `seg` codes:
  - IDLE: 0x00.
  - SETTLE/WATER, zone 0: 0x3F ("0").
  - SETTLE/WATER, zone 1: 0x06 ("1").
  - COOLDOWN: 0x40 ("-").
- Outputs are never both `pump`=1 and `valve`=0.

## Timing
- All outputs are registered and change only on `clk_2` rising edges or on reset assertion.
- Reset values:
  - state IDLE, `valve`=0, `pump`=0, `busy`=0, `seg`=0x00, `served`=0.
  - `last_served`=1, so zone 0 wins the first tie.
  - tick counter 0.
- `reset_n` low at any point, including mid-WATER, forces all reset values immediately (asynchronous). Release is sampled at the next edge.
- Latency, for a request sampled in IDLE at edge t:
  - SETTLE outputs are visible after t.
  - WATER starts at edge t+1, so `pump`=1 during cycles t+1 … t+`WATER_TICKS`.
  - COOLDOWN runs from t+`WATER_TICKS`+1.
  - IDLE is reached at t+`WATER_TICKS`+`COOLDOWN_TICKS`+1.
- A request that is still pending at the IDLE edge is granted on that same edge. IDLE therefore lasts 1 cycle minimum between services.
- Tick counter width is `$clog2(max(WATER_TICKS,COOLDOWN_TICKS)+1)`. It is reused in COOLDOWN and reset to 0 on each state entry.
- Back-to-back ties alternate zones strictly: 0, 1, 0, 1, …

## Structure
- Package `irrigation_pkg` holds:
  - the state typedef enum {IDLE, SETTLE, WATER, COOLDOWN};
  - the `seg` code constants SEG_BLANK=0x00, SEG_ZONE0=0x3F, SEG_ZONE1=0x06, SEG_COOL=0x40.
- One sub-module, `rr_arbiter2`:
  - Combinational grant from `dry` and `last_served`.
  - Output is a 1-bit grant index plus a `valid` signal.
- The FSM, counters and output registers stay in `irrigation_controller`.

## Test plan
- Reset then `dry`=01, `enable`=1 (defaults):
  - `valve`=01, `seg`=0x3F for 1 cycle, then `pump`=1 for 5 cycles.
  - Then `seg`=0x40 for 2 cycles.
  - Then IDLE, `served`=1.
- `dry`=11 held for 4 services: zones granted 0, 1, 0, 1, `served`=4, with exactly 1 IDLE cycle between services.
- `enable` dropped in the 3rd WATER cycle:
  - Next cycle is COOLDOWN, `pump`=0, `valve`=0, `served` unchanged.
  - The next tie still grants the same zone.
- `dry` dropped to 00 in SETTLE: watering still completes 5 pump cycles, `served` increments.
- `reset_n` pulsed low mid-WATER: `pump`, `valve`, `busy` and `served` go to 0 immediately without a clock edge. After release with `dry`=11, zone 0 is granted.
- `NBITS_CNT`=2 with 5 consecutive services: `served` saturates at 3.
